// File: rtl/cdc_hs_tx_ctrl_if.sv
// Handshake bundle for the cdc_hs_tx_ctrl transmit side.
//   SRC_DATA/SRC_VALID/SRC_READY : local requester word handshake
//   ACK_SYNC                     : destination acknowledge, already synchronized into CLK
//   ERR_CLR                      : clears the timeout error state
//   REQ/TX_DATA                  : registered four-phase request and data toward the destination
//   DONE/BUSY/TIMEOUT_ERR        : status
// Modport master is the environment side (requester + ack source), slave is the controller.
interface cdc_hs_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] SRC_DATA;
  logic                  SRC_VALID;
  logic                  SRC_READY;
  logic                  ACK_SYNC;
  logic                  ERR_CLR;
  logic                  REQ;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  DONE;
  logic                  BUSY;
  logic                  TIMEOUT_ERR;

  modport master (
    output SRC_DATA, SRC_VALID, ACK_SYNC, ERR_CLR,
    input  SRC_READY, REQ, TX_DATA, DONE, BUSY, TIMEOUT_ERR
  );

  modport slave (
    input  SRC_DATA, SRC_VALID, ACK_SYNC, ERR_CLR,
    output SRC_READY, REQ, TX_DATA, DONE, BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/cdc_hs_tx_ctrl.sv
// Four-phase request/acknowledge transmit controller for a clock-domain crossing.
// Accepts one word from a local requester, presents it on a registered TX_DATA bus with REQ,
// waits for ACK_SYNC to rise then fall, and pulses DONE. Each handshake phase is bounded by
// TIMEOUT_CYCLES (0 = unbounded); expiry parks the FSM in an error state until ERR_CLR.
// Ports:
//   CLK  - block clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - cdc_hs_tx_ctrl_if.slave (SRC_*, ACK_SYNC, ERR_CLR in; REQ, TX_DATA, status out)
module cdc_hs_tx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  cdc_hs_tx_ctrl_if.slave        bus
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StReqHi,
    StReqLo,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  done_q, done_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  accept;
  logic                  expired;

  // A stale-high ack from a previous transfer must drain before a new word is taken.
  assign bus.SRC_READY   = (state_q == StIdle) && !bus.ACK_SYNC;
  assign accept          = bus.SRC_VALID && bus.SRC_READY;
  assign expired         = TimeoutEn && (cnt_q == CntLast);

  assign bus.REQ         = req_q;
  assign bus.TX_DATA     = tx_data_q;
  assign bus.DONE        = done_q;
  assign bus.BUSY        = (state_q != StIdle);
  assign bus.TIMEOUT_ERR = (state_q == StErr);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    // Any phase change clears the counter; staying in a phase increments it below.
    cnt_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_data_d = bus.SRC_DATA;
          req_d     = 1'b1;
          state_d   = StReqHi;
        end
      end
      StReqHi: begin
        // Ack is tested first so it wins over a same-cycle expiry.
        if (bus.ACK_SYNC) begin
          req_d   = 1'b0;
          state_d = StReqLo;
        end else if (expired) begin
          req_d   = 1'b0;
          state_d = StErr;
        end else begin
          cnt_d = TimeoutEn ? cnt_q + 1'b1 : '0;
        end
      end
      StReqLo: begin
        if (!bus.ACK_SYNC) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (expired) begin
          req_d   = 1'b0;
          state_d = StErr;
        end else begin
          cnt_d = TimeoutEn ? cnt_q + 1'b1 : '0;
        end
      end
      StErr: begin
        if (bus.ERR_CLR && !bus.ACK_SYNC) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Self-checking bench for cdc_hs_tx_ctrl. Stimulus pushes each word it expects to be accepted
// into a scoreboard queue; a negedge monitor pops on every REQ rise and checks TX_DATA, checks
// TX_DATA stability while REQ is high, and counts DONE pulses. Directed checks cover reset,
// timeout, races, stale ack, back-to-back and async reset. A second instance has the timeout
// disabled.
module tb_cdc_hs_tx_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  cdc_hs_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();
  cdc_hs_tx_ctrl_if #(.DATA_WIDTH(8)) bus0 ();

  cdc_hs_tx_ctrl #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  cdc_hs_tx_ctrl #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (0)
  ) u_dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  int unsigned done_exp = 0;
  logic [7:0]  exp_q[$];
  logic        prev_req = 1'b0;
  logic [7:0]  held     = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge CLK) begin
    if (bus.REQ && !prev_req) begin
      check("accept_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("tx_data_on_req", 32'(bus.TX_DATA), 32'(exp_q.pop_front()));
      end
      held <= bus.TX_DATA;
    end else if (bus.REQ) begin
      check("tx_data_stable", 32'(bus.TX_DATA), 32'(held));
    end
    if (bus.DONE) done_cnt <= done_cnt + 1;
    prev_req <= bus.REQ;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SRC_DATA  = 8'h00;
    bus.SRC_VALID = 1'b0;
    bus.ACK_SYNC  = 1'b0;
    bus.ERR_CLR   = 1'b0;
    bus0.SRC_DATA  = 8'h00;
    bus0.SRC_VALID = 1'b0;
    bus0.ACK_SYNC  = 1'b0;
    bus0.ERR_CLR   = 1'b0;

    // Reset state.
    #1 RST = 1'b1;
    #1;
    check("rst_req", 32'(bus.REQ), 0);
    check("rst_tx_data", 32'(bus.TX_DATA), 0);
    check("rst_done", 32'(bus.DONE), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_terr", 32'(bus.TIMEOUT_ERR), 0);
    check("rst_ready", 32'(bus.SRC_READY), 1);
    bus.ACK_SYNC = 1'b1;
    #1 check("rst_ready_ack", 32'(bus.SRC_READY), 0);
    bus.ACK_SYNC = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus.SRC_READY), 1);

    // Nominal transfer of A5.
    bus.SRC_DATA  = 8'hA5;
    bus.SRC_VALID = 1'b1;
    exp_q.push_back(8'hA5);
    done_exp++;
    tick();
    bus.SRC_VALID = 1'b0;
    check("nom_req_hi", 32'(bus.REQ), 1);
    check("nom_tx", 32'(bus.TX_DATA), 32'hA5);
    check("nom_busy", 32'(bus.BUSY), 1);
    check("nom_ready_busy", 32'(bus.SRC_READY), 0);
    tick();
    tick();
    bus.ACK_SYNC = 1'b1;
    tick();
    check("nom_req_lo", 32'(bus.REQ), 0);
    check("nom_busy_lo", 32'(bus.BUSY), 1);
    tick();
    check("nom_no_done_yet", 32'(bus.DONE), 0);
    bus.ACK_SYNC = 1'b0;
    tick();
    check("nom_done", 32'(bus.DONE), 1);
    check("nom_idle", 32'(bus.BUSY), 0);
    tick();
    check("nom_done_pulse", 32'(bus.DONE), 0);
    check("nom_tx_held", 32'(bus.TX_DATA), 32'hA5);

    // Timeout in the request-high phase.
    bus.SRC_DATA  = 8'h3C;
    bus.SRC_VALID = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    bus.SRC_VALID = 1'b0;
    tick();
    tick();
    tick();
    check("to_not_yet", 32'(bus.TIMEOUT_ERR), 0);
    check("to_req_still", 32'(bus.REQ), 1);
    tick();
    check("to_err", 32'(bus.TIMEOUT_ERR), 1);
    check("to_req_drop", 32'(bus.REQ), 0);
    check("to_ready", 32'(bus.SRC_READY), 0);
    check("to_tx_held", 32'(bus.TX_DATA), 32'h3C);
    bus.ERR_CLR  = 1'b1;
    bus.ACK_SYNC = 1'b1;
    tick();
    check("to_hold_ack", 32'(bus.TIMEOUT_ERR), 1);
    bus.ACK_SYNC = 1'b0;
    tick();
    check("to_cleared", 32'(bus.TIMEOUT_ERR), 0);
    check("to_clear_idle", 32'(bus.BUSY), 0);
    check("to_no_done", 32'(bus.DONE), 0);
    bus.ERR_CLR = 1'b0;
    tick();

    // Timeout in the request-low phase (ack stuck high).
    bus.SRC_DATA  = 8'h4B;
    bus.SRC_VALID = 1'b1;
    exp_q.push_back(8'h4B);
    tick();
    bus.SRC_VALID = 1'b0;
    bus.ACK_SYNC  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("tolo_not_yet", 32'(bus.TIMEOUT_ERR), 0);
    tick();
    check("tolo_err", 32'(bus.TIMEOUT_ERR), 1);
    bus.ERR_CLR  = 1'b1;
    bus.ACK_SYNC = 1'b0;
    tick();
    check("tolo_cleared", 32'(bus.TIMEOUT_ERR), 0);
    check("tolo_no_done", 32'(bus.DONE), 0);
    bus.ERR_CLR = 1'b0;
    tick();

    // Ack versus expiry race on the 4th request-high cycle; ERR_CLR ignored outside ERR.
    bus.SRC_DATA  = 8'h5A;
    bus.SRC_VALID = 1'b1;
    exp_q.push_back(8'h5A);
    done_exp++;
    tick();
    bus.SRC_VALID = 1'b0;
    bus.ERR_CLR   = 1'b1;
    tick();
    tick();
    tick();
    check("race_still_hi", 32'(bus.REQ), 1);
    bus.ACK_SYNC = 1'b1;
    tick();
    check("race_no_err", 32'(bus.TIMEOUT_ERR), 0);
    check("race_req_lo", 32'(bus.REQ), 0);
    check("race_busy", 32'(bus.BUSY), 1);
    bus.ERR_CLR  = 1'b0;
    bus.ACK_SYNC = 1'b0;
    tick();
    check("race_done", 32'(bus.DONE), 1);
    tick();

    // Stale ack blocks acceptance.
    bus.ACK_SYNC  = 1'b1;
    bus.SRC_DATA  = 8'h77;
    bus.SRC_VALID = 1'b1;
    #1 check("stale_ready", 32'(bus.SRC_READY), 0);
    tick();
    tick();
    check("stale_no_req", 32'(bus.REQ), 0);
    check("stale_idle", 32'(bus.BUSY), 0);
    bus.ACK_SYNC = 1'b0;
    exp_q.push_back(8'h77);
    done_exp++;
    #1 check("stale_ready_back", 32'(bus.SRC_READY), 1);
    tick();
    bus.SRC_VALID = 1'b0;
    check("stale_req", 32'(bus.REQ), 1);
    check("stale_tx", 32'(bus.TX_DATA), 32'h77);
    bus.ACK_SYNC = 1'b1;
    tick();
    bus.ACK_SYNC = 1'b0;
    tick();
    check("stale_done", 32'(bus.DONE), 1);
    tick();

    // Back-to-back with SRC_VALID held high; 22 is presented early and must wait.
    bus.SRC_DATA  = 8'h11;
    bus.SRC_VALID = 1'b1;
    exp_q.push_back(8'h11);
    done_exp += 2;
    tick();
    bus.SRC_DATA = 8'h22;
    bus.ACK_SYNC = 1'b1;
    tick();
    bus.ACK_SYNC = 1'b0;
    tick();
    check("b2b_done1", 32'(bus.DONE), 1);
    check("b2b_tx_held", 32'(bus.TX_DATA), 32'h11);
    check("b2b_ready", 32'(bus.SRC_READY), 1);
    exp_q.push_back(8'h22);
    tick();
    bus.SRC_VALID = 1'b0;
    check("b2b_req2", 32'(bus.REQ), 1);
    check("b2b_tx2", 32'(bus.TX_DATA), 32'h22);
    check("b2b_done_pulse", 32'(bus.DONE), 0);
    bus.ACK_SYNC = 1'b1;
    tick();
    bus.ACK_SYNC = 1'b0;
    tick();
    check("b2b_done2", 32'(bus.DONE), 1);
    tick();

    // Async reset mid request-high, asserted after the monitor has seen REQ rise.
    bus.SRC_DATA  = 8'h99;
    bus.SRC_VALID = 1'b1;
    exp_q.push_back(8'h99);
    tick();
    bus.SRC_VALID = 1'b0;
    check("arst_req_before", 32'(bus.REQ), 1);
    #5 RST = 1'b1;
    #1;
    check("arst_req", 32'(bus.REQ), 0);
    check("arst_tx", 32'(bus.TX_DATA), 0);
    check("arst_busy", 32'(bus.BUSY), 0);
    tick();
    RST = 1'b0;
    tick();
    check("arst_idle", 32'(bus.BUSY), 0);
    check("arst_no_done", 32'(bus.DONE), 0);
    tick();

    // Timeout disabled: request may wait indefinitely.
    bus0.SRC_DATA  = 8'hC3;
    bus0.SRC_VALID = 1'b1;
    tick();
    bus0.SRC_VALID = 1'b0;
    check("nto_req", 32'(bus0.REQ), 1);
    repeat (12) tick();
    check("nto_no_err", 32'(bus0.TIMEOUT_ERR), 0);
    check("nto_req_held", 32'(bus0.REQ), 1);
    check("nto_tx", 32'(bus0.TX_DATA), 32'hC3);
    bus0.ACK_SYNC = 1'b1;
    repeat (12) tick();
    check("nto_lo_no_err", 32'(bus0.TIMEOUT_ERR), 0);
    check("nto_req_lo", 32'(bus0.REQ), 0);
    bus0.ACK_SYNC = 1'b0;
    tick();
    check("nto_done", 32'(bus0.DONE), 1);
    tick();

    check("done_count", done_cnt, done_exp);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx_ctrl.md
CDC_HS_TX_CTRL -- requirements
Module: cdc_hs_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the transferred word.
REQ-002 Parameter TIMEOUT_CYCLES, default 255; maximum wait per handshake phase, in CLK cycles; 0 disables the timeout.
REQ-003 CLK  input  1  single block clock, rising-edge active.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 SRC_DATA  input  DATA_WIDTH  word to transfer from the local requester.
REQ-006 SRC_VALID  input  1  requester has a word on SRC_DATA.
REQ-007 SRC_READY  output  1  block can accept a word this cycle.
REQ-008 ACK_SYNC  input  1  destination acknowledge, already synchronized into CLK by an external bit synchronizer.
REQ-009 ERR_CLR  input  1  clears the timeout error state.
REQ-010 REQ  output  1  registered four-phase request toward the destination domain.
REQ-011 TX_DATA  output  DATA_WIDTH  registered data bus crossing to the destination; stable while REQ is high.
REQ-012 DONE  output  1  one-cycle pulse when a transfer fully completes.
REQ-013 BUSY  output  1  high in any state other than IDLE.
REQ-014 TIMEOUT_ERR  output  1  high while in the ERR state.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ_HI, REQ_LO and ERR, all registered.
REQ-016 In IDLE: SRC_READY = !ACK_SYNC; a stale-high ack blocks acceptance.
REQ-017 Accept occurs when SRC_VALID && SRC_READY: TX_DATA <= SRC_DATA, REQ <= 1, and the next state is REQ_HI; REQ therefore rises 1 cycle after accept.
REQ-018 SRC_READY SHALL be 0 in REQ_HI, REQ_LO and ERR.
REQ-019 In REQ_HI, ACK_SYNC == 1: REQ <= 0 and the next state is REQ_LO.
REQ-020 In REQ_LO, ACK_SYNC == 0: the next state is IDLE and DONE = 1 for exactly the cycle the FSM enters IDLE.
REQ-021 TX_DATA SHALL change only on accept; it is held through REQ_HI, REQ_LO, ERR and IDLE.
REQ-022 The timeout counter (width clog2(TIMEOUT_CYCLES+1), minimum 1) SHALL clear on entry to REQ_HI and on entry to REQ_LO, and increment every cycle spent in those states.
REQ-023 Timeout expiry in REQ_HI or REQ_LO is counter == TIMEOUT_CYCLES-1 with the exit condition false; the FSM then goes to ERR and REQ <= 0.
REQ-024 If the ack exit condition and the expiry occur in the same cycle, the ack SHALL win with a normal transition and no error.
REQ-025 When TIMEOUT_CYCLES == 0, the counter SHALL stay at 0 and ERR SHALL be unreachable.
REQ-026 ERR SHALL exit to IDLE only when ERR_CLR == 1 && ACK_SYNC == 0; otherwise it holds. DONE is not pulsed on this exit.
REQ-027 ERR_CLR SHALL be ignored outside ERR.
REQ-028 SRC_VALID SHALL be ignored while SRC_READY == 0; no word is queued.
REQ-029 Back-to-back transfers: accept is allowed in the same cycle DONE is high, provided SRC_VALID is high and ACK_SYNC is 0.

Reset
REQ-030 While RST = 1, regardless of CLK: state = IDLE, REQ = 0, TX_DATA = 0, DONE = 0, counter = 0, TIMEOUT_ERR = 0, BUSY = 0.
REQ-031 SRC_READY SHALL follow !ACK_SYNC combinationally during and after reset.
REQ-032 Reset mid-handshake SHALL drop REQ immediately, abandon the transfer and issue no DONE.
REQ-033 Reset deassertion SHALL take effect on the next CLK rising edge.

Verification
REQ-034 Nominal transfer: SRC_DATA = 8'hA5 with SRC_VALID pulsed; ACK_SYNC rises 3 cycles after REQ and falls 2 cycles after REQ falls -> TX_DATA = A5 with REQ high 1 cycle after accept; REQ low 1 cycle after ack high; one DONE pulse; BUSY low afterwards.
REQ-035 Timeout: TIMEOUT_CYCLES = 4 and ACK_SYNC held 0 after accept -> ERR entered after 4 cycles in REQ_HI; TIMEOUT_ERR = 1, REQ = 0, SRC_READY = 0. Then ERR_CLR = 1 with ACK_SYNC = 1 -> stays in ERR; ERR_CLR = 1 with ACK_SYNC = 0 -> IDLE, no DONE.
REQ-036 Ack versus timeout race: TIMEOUT_CYCLES = 4 and ACK_SYNC rises on the 4th REQ_HI cycle -> REQ_LO entered, TIMEOUT_ERR stays 0.
REQ-037 Stale ack: ACK_SYNC = 1 in IDLE with SRC_VALID = 1 -> SRC_READY = 0 and no accept until ACK_SYNC = 0, then accept on the next cycle.
REQ-038 Back-to-back: words 8'h11 and 8'h22 with SRC_VALID held high -> the second accept occurs in the DONE cycle; TX_DATA stays 11 until that accept; two DONE pulses.
REQ-039 Async reset: RST asserted mid-cycle in REQ_HI -> REQ = 0 and TX_DATA = 0 before the next CLK edge; no DONE; IDLE after release.
